// File: rtl/halt_report_writer_pkg.sv
// Shared constants and FSM state type for the halt report writer.
// Holds the ASCII glyphs, the default halt opcode and the report layout.
package report_pkg;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [5:0] HALT_OP_DEF = 6'b111111;

  localparam logic [4:0] LINE_W     = 5'd16;
  localparam logic [3:0] HEX_COL0   = 4'd2;
  localparam logic [3:0] HEX_DIGITS = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/halt_report_writer_hex_ascii.sv
// Nibble to uppercase ASCII hex digit converter.
// Purely combinational.
module hex_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 0-9 map to '0'..'9', 10-15 map to 'A'..'F'
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else begin
      ascii = 8'h37 + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/halt_report_writer.sv
// Captures self-check values on the write-stage halt and streams a 4x16
// ASCII pass/fail report into the display character buffer.
module halt_report_writer
  import report_pkg::*;
#(
  parameter logic [5:0]  HALT_OP = HALT_OP_DEF,
  parameter logic [31:0] EXP0    = 32'd55,
  parameter logic [31:0] EXP1    = 32'd987,
  parameter logic [31:0] EXP2    = 32'd97,
  parameter logic [31:0] EXP3    = 32'h00000315
) (
  input  logic        sysclk,
  input  logic        rstd,
  input  logic [5:0]  op_w,
  input  logic [31:0] count,
  input  logic [31:0] val0,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [31:0] val3,
  input  logic        wr_ready,
  output logic        we,
  output logic [5:0]  write_addr,
  output logic [7:0]  write_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] cycles
);

  state_e            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [3:0][31:0]  cap_q, cap_d;
  logic [3:0]        match_q, match_d;
  logic [31:0]       cycles_q, cycles_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [1:0]        line_s;
  logic [3:0]        col_s;
  logic [31:0]       line_val_s;
  logic [3:0]        nibble_s;
  logic [7:0]        hex_ch_s;
  logic [7:0]        char_s;

  // Next-state logic: capture on halt, advance on accepted writes
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cap_d    = cap_q;
    match_d  = match_q;
    cycles_d = cycles_q;
    we_d     = we_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE: begin
        if (op_w == HALT_OP) begin
          cap_d    = {val3, val2, val1, val0};
          match_d  = {val3 == EXP3, val2 == EXP2, val1 == EXP1, val0 == EXP0};
          cycles_d = count + 32'd1;
          idx_d    = 6'd0;
          state_d  = WRITE;
          we_d     = 1'b1;
          busy_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (we_q && wr_ready) begin
          if (idx_q == 6'd63) begin
            state_d = DONE;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = &match_q;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else begin
          state_d = WRITE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase
  end

  // State and capture registers
  always_ff @(posedge sysclk or negedge rstd) begin
    if (!rstd) begin
      state_q  <= IDLE;
      idx_q    <= 6'd0;
      cap_q    <= '0;
      match_q  <= 4'h0;
      cycles_q <= 32'd0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cap_q    <= cap_d;
      match_q  <= match_d;
      cycles_q <= cycles_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign line_s     = idx_q[5:4];
  assign col_s      = idx_q[3:0];
  assign line_val_s = cap_q[line_s];

  // Column 2 shows the most significant nibble, column 9 the least
  always_comb begin
    case (col_s)
      4'd2:    nibble_s = line_val_s[31:28];
      4'd3:    nibble_s = line_val_s[27:24];
      4'd4:    nibble_s = line_val_s[23:20];
      4'd5:    nibble_s = line_val_s[19:16];
      4'd6:    nibble_s = line_val_s[15:12];
      4'd7:    nibble_s = line_val_s[11:8];
      4'd8:    nibble_s = line_val_s[7:4];
      default: nibble_s = line_val_s[3:0];
    endcase
  end

  hex_ascii u_hex_ascii (
    .nibble (nibble_s),
    .ascii  (hex_ch_s)
  );

  // Character for the current index: flag, gap, eight hex digits, padding
  always_comb begin
    char_s = CH_SPACE;
    if (col_s == 4'd0) begin
      char_s = match_q[line_s] ? CH_PLUS : CH_MINUS;
    end else if ((col_s >= HEX_COL0) && (col_s < (HEX_COL0 + HEX_DIGITS))) begin
      char_s = hex_ch_s;
    end else begin
      char_s = CH_SPACE;
    end
  end

  assign we         = we_q;
  assign write_addr = idx_q;
  assign write_data = we_q ? char_s : CH_SPACE;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign cycles     = cycles_q;

endmodule
